// File: rtl/gf2_syndrome_seq_pkg.sv
// Shared types and helpers for the GF(2) syndrome sequencer.
// Used by gf2_syndrome_seq and gf2_chunk_mul.
package gf2_pkg;

    typedef enum logic [0:0] {
        StAcc,
        StHold
    } gf2_state_e;

    // Counter width; $clog2(1) would be 0, so clamp to 1.
    function automatic int unsigned gf2_clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Flat index of H(r, k) for a matrix with n columns.
    function automatic int unsigned hidx(input int unsigned r, input int unsigned k,
                                         input int unsigned n);
        return r * n + k;
    endfunction

endpackage

// File: rtl/gf2_syndrome_seq_if.sv
// Chunk-in / syndrome-out handshake bundle for gf2_syndrome_seq.
// GF2_SYNDROME_SEQ_ZERO_FLAG_EN adds the out_zero signal.
interface gf2_syndrome_seq_if #(
    parameter int unsigned W = 8,
    parameter int unsigned R = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [R-1:0] out_syndrome;
`ifdef GF2_SYNDROME_SEQ_ZERO_FLAG_EN
    logic         out_zero;

    modport master (
        output in_valid, in_data, abort, out_ready,
        input  in_ready, out_valid, out_syndrome, out_zero
    );
    modport slave (
        input  in_valid, in_data, abort, out_ready,
        output in_ready, out_valid, out_syndrome, out_zero
    );
`else
    modport master (
        output in_valid, in_data, abort, out_ready,
        input  in_ready, out_valid, out_syndrome
    );
    modport slave (
        input  in_valid, in_data, abort, out_ready,
        output in_ready, out_valid, out_syndrome
    );
`endif
endinterface

// File: rtl/gf2_syndrome_seq_chunk_mul.sv
// Combinational product of one W-bit message chunk with the R x W column slice
// of H selected at run time by the chunk index.
module gf2_chunk_mul
    import gf2_pkg::*;
#(
    parameter int unsigned   W  = 8,
    parameter int unsigned   R  = 8,
    parameter int unsigned   N  = 32,
    parameter int unsigned   CW = 2,
    parameter logic [R*N-1:0] H = '0
) (
    input  logic [W-1:0]  i_chunk,
    input  logic [CW-1:0] i_idx,
    output logic [R-1:0]  o_prod
);
    localparam int unsigned NChunk = N / W;

    always_comb begin
        o_prod = '0;
        for (int unsigned c = 0; c < NChunk; c++) begin
            if (i_idx == CW'(c)) begin
                for (int unsigned r = 0; r < R; r++) begin
                    for (int unsigned j = 0; j < W; j++) begin
                        o_prod[r] = o_prod[r] ^ (i_chunk[j] & H[hidx(r, c * W + j, N)]);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/gf2_syndrome_seq.sv
// Streams an N-bit message in W-bit chunks and XOR-accumulates H x message.
// Optional out_zero flag under GF2_SYNDROME_SEQ_ZERO_FLAG_EN.
module gf2_syndrome_seq
    import gf2_pkg::*;
#(
    parameter int unsigned          W      = 8,
    parameter int unsigned          NCHUNK = 4,
    parameter int unsigned          R      = 8,
    parameter logic [R*W*NCHUNK-1:0] H     = '0
) (
    input logic              clk,
    input logic              reset,
    gf2_syndrome_seq_if.slave bus
);
    localparam int unsigned   N       = W * NCHUNK;
    localparam int unsigned   CW      = gf2_clog2_min1(NCHUNK);
    localparam logic [CW-1:0] LastIdx = CW'(NCHUNK - 1);

    gf2_state_e    r_state;
    gf2_state_e    w_state_next;
    logic [CW-1:0] r_count;
    logic [R-1:0]  r_acc;
    logic [R-1:0]  r_syndrome;
    logic [R-1:0]  w_prod;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_last;

    // abort blocks acceptance so a chunk presented with it is simply dropped
    assign w_in_ready = (r_state == StAcc) && !bus.abort;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = (r_count == LastIdx);

    gf2_chunk_mul #(
        .W  (W),
        .R  (R),
        .N  (N),
        .CW (CW),
        .H  (H)
    ) u_mul (
        .i_chunk (bus.in_data),
        .i_idx   (r_count),
        .o_prod  (w_prod)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StAcc;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StAcc:   if (w_accept && w_last) w_state_next = StHold;
            StHold:  if (bus.out_ready)      w_state_next = StAcc;
            default: w_state_next = StAcc;
        endcase
    end

    always_comb begin
        bus.in_ready     = w_in_ready;
        bus.out_valid    = (r_state == StHold);
        bus.out_syndrome = r_syndrome;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_syndrome <= '0;
        end else if (r_state == StAcc) begin
            if (bus.abort) begin
                r_count <= '0;
                r_acc   <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_syndrome <= r_acc ^ w_prod;
                    r_acc      <= '0;
                    r_count    <= '0;
                end else begin
                    r_acc   <= r_acc ^ w_prod;
                    r_count <= r_count + CW'(1);
                end
            end
        end
    end

`ifdef GF2_SYNDROME_SEQ_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero <= 1'b0;
        end else if (w_accept && w_last) begin
            r_zero <= ~|(r_acc ^ w_prod);
        end
    end

    assign bus.out_zero = r_zero;
`endif

endmodule

// File: tb/tb_gf2_syndrome_seq.sv
// Scoreboard bench for gf2_syndrome_seq with W=2, NCHUNK=2, R=2, H=8'b1010_0011.
module tb_gf2_syndrome_seq;
    localparam int unsigned W      = 2;
    localparam int unsigned NCHUNK = 2;
    localparam int unsigned R      = 2;
    localparam int unsigned N      = W * NCHUNK;
    localparam logic [R*N-1:0] HMAT = 8'b1010_0011;

    logic clk = 1'b0;
    logic reset;
    logic rand_mode = 1'b0;
    logic ready_ctl = 1'b0;
    logic rnd_ready = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [R-1:0] exp_q[$];

    gf2_syndrome_seq_if #(.W(W), .R(R)) bus ();

    gf2_syndrome_seq #(
        .W      (W),
        .NCHUNK (NCHUNK),
        .R      (R),
        .H      (HMAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.out_ready = rand_mode ? rnd_ready : ready_ctl;

    initial begin
        forever begin
            @(posedge clk);
            #1 rnd_ready = 1'($urandom_range(0, 1));
        end
    end

    // Reference: syndrome bit r is the parity of the message masked by row r of H.
    function automatic logic [R-1:0] ref_syn(input logic [N-1:0] msg);
        logic [R*N-1:0] h;
        logic [R-1:0]   s;
        h = HMAT;
        for (int r = 0; r < int'(R); r++) s[r] = ^(msg & h[r*N +: N]);
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_chunk(input logic [W-1:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready 0 required=in_ready 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
    endtask

    task automatic send_msg(input logic [W-1:0] c0, input logic [W-1:0] c1, input int gap);
        send_chunk(c0);
        idle(gap);
        exp_q.push_back(ref_syn({c1, c0}));
        send_chunk(c1);
    endtask

    // Monitor: every output handshake must match the oldest expected syndrome.
    initial begin
        logic [R-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", bus.out_syndrome);
                end else begin
                    e = exp_q.pop_front();
                    chk("syndrome", 32'(bus.out_syndrome), 32'(e));
`ifdef GF2_SYNDROME_SEQ_ZERO_FLAG_EN
                    chk("out_zero", 32'(bus.out_zero), 32'(e == '0));
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.abort    = 1'b0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_syndrome", 32'(bus.out_syndrome), 0);
`ifdef GF2_SYNDROME_SEQ_ZERO_FLAG_EN
        chk("rst_zero", 32'(bus.out_zero), 0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // 1: 01,00 -> 01, one cycle after the last handshake
        ready_ctl = 1'b1;
        send_chunk(2'b01);
        chk("t1_no_early_valid", 32'(bus.out_valid), 0);
        exp_q.push_back(2'b01);
        send_chunk(2'b00);
        chk("t1_latency_valid", 32'(bus.out_valid), 1);
        chk("t1_in_ready_low", 32'(bus.in_ready), 0);
        idle(2);

        // 2: 11,10 -> 00
        send_msg(2'b11, 2'b10, 0);
        idle(2);

        // 3: hold with out_ready low; abort must not disturb the result
        ready_ctl = 1'b0;
        send_msg(2'b01, 2'b00, 1);
        bus.abort = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(bus.out_valid), 1);
            chk("t3_hold_in_ready", 32'(bus.in_ready), 0);
            chk("t3_hold_syndrome", 32'(bus.out_syndrome), 2'b01);
        end
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        ready_ctl = 1'b1;
        idle(1);
        ready_ctl = 1'b0;
        chk("t3_release_in_ready", 32'(bus.in_ready), 1);
        chk("t3_release_valid", 32'(bus.out_valid), 0);

        // 4: 01, abort (with a chunk offered), then 00,00 -> 00
        ready_ctl = 1'b1;
        send_chunk(2'b01);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 2'b01;
        @(negedge clk);
        chk("t4_abort_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        chk("t4_abort_no_valid", 32'(bus.out_valid), 0);
        send_msg(2'b00, 2'b00, 0);
        idle(2);

        // 5: reset mid-message, then 01,00 -> 01; then reset while holding 11
        send_chunk(2'b01);
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(bus.out_valid), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("t5_rst_in_ready", 32'(bus.in_ready), 1);
        send_msg(2'b01, 2'b00, 0);
        idle(2);
        ready_ctl = 1'b0;
        send_msg(2'b10, 2'b00, 0);
        @(negedge clk);
        chk("t5_hold_syndrome", 32'(bus.out_syndrome), 2'b11);
        reset = 1'b1;
        #1;
        chk("t5_rst_hold_valid", 32'(bus.out_valid), 0);
        chk("t5_rst_hold_syndrome", 32'(bus.out_syndrome), 0);
`ifdef GF2_SYNDROME_SEQ_ZERO_FLAG_EN
        chk("t5_rst_hold_zero", 32'(bus.out_zero), 0);
`endif
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;

        // 6: random gaps, random back-pressure, occasional aborted partial message
        rand_mode = 1'b1;
        for (int m = 0; m < 200; m++) begin
            if ($urandom_range(0, 7) == 0) begin
                send_chunk(W'($urandom));
                bus.abort = 1'b1;
                idle(1);
                bus.abort = 1'b0;
            end
            idle($urandom_range(0, 2));
            send_msg(W'($urandom), W'($urandom), $urandom_range(0, 2));
        end
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("t6_drained", 32'(exp_q.size()), 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf2_syndrome_seq.md
Name: gf2_syndrome_seq

Overview:
Sequential GF(2) matrix-vector multiplier. It streams an N-bit message in W-bit chunks through a valid/ready handshake and multiplies each chunk by the matching column slice of a constant R x N parity-check matrix H. Partial products are XOR-accumulated into an R-bit syndrome. It sits between the framer and the decoder's error-locate stage and replaces a full-width combinational multiply when N is too wide for one cycle.

Parameters:
W, 8, chunk width in message bits
NCHUNK, 4, chunks per message; N = W*NCHUNK
R, 8, syndrome width (rows of H)
H, 0, [R*N-1:0] constant matrix; bit H[r*N+k] multiplies message bit k into syndrome bit r

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  chunk valid
in_ready  out  1  block accepts chunk
in_data  in  W  chunk; chunk c carries message bits [c*W +: W]
abort  in  1  synchronous discard of the in-flight message
out_valid  out  1  syndrome valid
out_ready  in  1  consumer accepts syndrome
out_syndrome  out  R  accumulated syndrome

Behaviour:
- Reset (async, active-high): state=ACC, chunk count=0, accumulator=0, out_valid=0, out_syndrome=0, in_ready=1 after reset deasserts.
- States:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Partial product for chunk c is combinational: p[r] = XOR over j<W of (in_data[j] & H[r*N + c*W + j]).
- ACC, on accept (in_valid & in_ready):
  - acc <= acc ^ p.
  - If count==NCHUNK-1: out_syndrome <= acc ^ p, count <= 0, acc <= 0, go to HOLD.
  - Otherwise count <= count+1.
- Latency: out_valid rises 1 cycle after the last chunk handshake.
- HOLD: out_syndrome is stable while out_valid=1 and out_ready=0. On out_ready: out_valid <= 0 and go to ACC. The next chunk is accepted no earlier than the following cycle; there is no overlap.
- abort:
  - In ACC: acc <= 0 and count <= 0 in the same cycle. A chunk presented that cycle is dropped and not accepted (in_ready held 0 while abort=1).
  - In HOLD: abort is ignored; the completed result is always delivered.
- NCHUNK=1: every accepted chunk goes straight to HOLD.
- Count width is $clog2(NCHUNK) with a minimum of 1; count never wraps past NCHUNK-1.
- H=0: out_syndrome is always 0, but the handshake timing is unchanged.
- in_data is ignored when in_valid=0. Inputs are not registered.

Optional Feature:
Macro GF2_SYNDROME_SEQ_ZERO_FLAG_EN.
- Defined: adds output out_zero (1 bit), registered alongside out_syndrome. It equals 1 iff the syndrome is all-zero (valid codeword) and resets to 0.
- Undefined: no out_zero port and no extra logic. Other behaviour is identical.

Decomposition:
- Shared package gf2_pkg:
  - state enum {ACC, HOLD}.
  - function gf2_clog2_min1.
  - H bit-index helper hidx(r,k) = r*N+k.
- Sub-module gf2_chunk_mul (combinational): W-bit chunk x runtime-selected R x W slice of H, producing R bits. It is parameterised on W, R, N, H and takes the chunk index as an input.

Test Plan:
Parameters for all scenarios: W=2, NCHUNK=2, R=2, H=8'b1010_0011, giving row0 = m0^m1 and row1 = m1^m3.
1. Chunks 2'b01 then 2'b00, back-to-back, out_ready=1 -> out_syndrome=2'b01 with out_valid one cycle after the 2nd handshake; out_zero=0.
2. Chunks 2'b11 then 2'b10 -> syndrome 2'b00; out_zero=1.
3. Hold out_ready=0 for 5 cycles after the result -> out_syndrome held and in_ready=0 throughout. Then pulse out_ready -> in_ready=1 on the next cycle.
4. Send chunk 2'b01, assert abort, then send chunks 2'b00 and 2'b00 -> syndrome 2'b00 (the aborted chunk has no effect).
5. Assert reset mid-message after one chunk -> outputs return to reset values at once. Sending 2'b01 then 2'b00 afterwards -> 2'b01.
6. Random in_valid/out_ready gaps over 200 messages -> compare against a reference model computing H x message; zero mismatches.
